// File: rtl/vga_pkg.sv
// Shared VGA timing constants and frame buffer types.
// Defaults give 640x480@60 over a 320x240 RGB444 frame buffer.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int FB_WIDTH_D = 320;

  localparam int H_TOTAL =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int HS_START = H_ACTIVE_D + H_FP_D;
  localparam int HS_END   = HS_START + H_SYNC_D - 1;
  localparam int VS_START = V_ACTIVE_D + V_FP_D;
  localparam int VS_END   = VS_START + V_SYNC_D - 1;

  typedef logic [11:0] pixel_t;
  typedef logic [16:0] fb_addr_t;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with position decode.
// Ports: clk_i, rst_i in; hpix_o (h/2), v_odd_o, row_act_o,
// active_o, hs_o, vs_o, fs_o, line_end_o, frame_end_o out.
// All decode outputs are combinational from the counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(HT),
  localparam int VW = $clog2(VT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-2:0] hpix_o,
  output logic          v_odd_o,
  output logic          row_act_o,
  output logic          active_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          fs_o,
  output logic          line_end_o,
  output logic          frame_end_o
);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E   =
    HW'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E   =
    VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign hpix_o      = h_q[HW-1:1];
  assign v_odd_o     = v_q[0];
  assign row_act_o   = (v_q < V_ACT);
  assign active_o    = (h_q < H_ACT) && row_act_o;
  assign hs_o        = (h_q >= HS_B) && (h_q <= HS_E);
  assign vs_o        = (v_q >= VS_B) && (v_q <= VS_E);
  assign fs_o        = (h_q == '0) && (v_q == '0);
  assign line_end_o  = h_last;
  assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/frame_buffer_reader.sv
// Frame buffer read engine: VGA timing, 2x2 scaled RAM reads,
// and pin-aligned RGB/syncs. Ports: clk_i, rst_i, read_data_i in;
// read_en_o, read_address_o, rgb_o, hsync_o, vsync_o,
// frame_start_o out. Position-to-pins latency is 3 clocks.
module frame_buffer_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter int FB_WIDTH   = FB_WIDTH_D,
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = 17,
  localparam int HW =
    $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  read_en_o,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  input  logic [WIDTH-1:0]      read_data_i,
  output logic [WIDTH-1:0]      rgb_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  frame_start_o
);

  localparam logic [ADDR_WIDTH-1:0] FB_STEP =
    ADDR_WIDTH'(FB_WIDTH);

  logic [HW-2:0] hpix;
  logic          v_odd, row_act, active;
  logic          hs, vs, fs, line_end, frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hpix_o      (hpix),
    .v_odd_o     (v_odd),
    .row_act_o   (row_act),
    .active_o    (active),
    .hs_o        (hs),
    .vs_o        (vs),
    .fs_o        (fs),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] pix_addr;

  // Row base steps once per pair of lines, replacing v/2*FB_WIDTH.
  always_comb begin
    base_d = base_q;
    if (frame_end) begin
      base_d = '0;
    end else if (line_end && row_act && v_odd) begin
      base_d = base_q + FB_STEP;
    end
  end

  assign pix_addr = base_q + ADDR_WIDTH'(hpix);

  logic                  re_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  act_b_q, hs_b_q, vs_b_q, fs_b_q;
  logic                  act_c_q, hs_c_q, vs_c_q, fs_c_q;
  logic [WIDTH-1:0]      rgb_q;
  logic                  hsync_q, vsync_q, fstart_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q   <= '0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      act_b_q  <= 1'b0;
      hs_b_q   <= 1'b0;
      vs_b_q   <= 1'b0;
      fs_b_q   <= 1'b0;
      act_c_q  <= 1'b0;
      hs_c_q   <= 1'b0;
      vs_c_q   <= 1'b0;
      fs_c_q   <= 1'b0;
      rgb_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fstart_q <= 1'b0;
    end else begin
      base_q <= base_d;
      // Address stage: RAM sees the request here.
      re_q    <= active;
      if (active) begin
        addr_q <= pix_addr;
      end
      act_b_q <= active;
      hs_b_q  <= hs;
      vs_b_q  <= vs;
      fs_b_q  <= fs;
      // Wait stage: RAM registers its read data.
      act_c_q <= act_b_q;
      hs_c_q  <= hs_b_q;
      vs_c_q  <= vs_b_q;
      fs_c_q  <= fs_b_q;
      // Pin stage: blanking forced to black.
      rgb_q    <= act_c_q ? read_data_i : '0;
      hsync_q  <= ~hs_c_q;
      vsync_q  <= ~vs_c_q;
      fstart_q <= fs_c_q;
    end
  end

  assign read_en_o      = re_q;
  assign read_address_o = addr_q;
  assign rgb_o          = rgb_q;
  assign hsync_o        = hsync_q;
  assign vsync_o        = vsync_q;
  assign frame_start_o  = fstart_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader.
// Vertical timing is shortened so whole frames fit the run.
module tb_frame_buffer_reader;

  localparam int HA  = 640;
  localparam int HF  = 16;
  localparam int HS  = 96;
  localparam int HB  = 48;
  localparam int VA  = 6;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int FBW = 320;
  localparam int HT  = 800;
  localparam int VT  = 13;
  localparam int FRAME = 10400;
  localparam int MAXA  = 959;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        read_en_o;
  logic [16:0] read_address_o;
  logic [11:0] read_data_i;
  logic [11:0] rgb_o;
  logic        hsync_o, vsync_o, frame_start_o;

  frame_buffer_reader #(
    .H_ACTIVE (HA), .H_FP (HF),
    .H_SYNC   (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF),
    .V_SYNC   (VS), .V_BP (VB),
    .FB_WIDTH (FBW),
    .WIDTH    (12),
    .ADDR_WIDTH (17)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .read_en_o      (read_en_o),
    .read_address_o (read_address_o),
    .read_data_i    (read_data_i),
    .rgb_o          (rgb_o),
    .hsync_o        (hsync_o),
    .vsync_o        (vsync_o),
    .frame_start_o  (frame_start_o)
  );

  always #5 clk = ~clk;

  logic [11:0] ram_q = '0;
  always @(posedge clk) begin
    if (read_en_o === 1'b1) ram_q <= read_address_o[11:0];
  end
  assign read_data_i = ram_q;

  typedef struct {
    bit act; bit hs; bit vs; bit fs; int pa;
  } pos_t;

  typedef struct {
    logic re; logic [16:0] addr; logic [11:0] rgb;
    logic hs_n; logic vs_n; logic fs;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   done = 0;
  bit   per_done = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic pos_t dec(input int h, input int v);
    pos_t d;
    d.act = (h < HA) && (v < VA);
    d.hs  = (h >= HA + HF) && (h < HA + HF + HS);
    d.vs  = (v >= VA + VF) && (v < VA + VF + VS);
    d.fs  = (h == 0) && (v == 0);
    d.pa  = (v / 2) * FBW + h / 2;
    return d;
  endfunction

  initial begin : driver
    pos_t z, s1, s2, s3;
    exp_t e;
    logic [16:0] held;
    int mh, mv, frames, tail;
    bit mid;
    z = '{default: 0};
    s1 = z; s2 = z; s3 = z;
    held = '0; mh = 0; mv = 0;
    frames = 0; tail = 0; mid = 0;
    for (int n = 0; n < 40000; n++) begin
      @(posedge clk);
      if (rst_i) begin
        s1 = z; s2 = z; s3 = z;
        held = '0; mh = 0; mv = 0;
      end else begin
        s3 = s2; s2 = s1;
        s1 = dec(mh, mv);
        if (s1.act) held = 17'(s1.pa);
        if (mh == HT - 1) begin
          mh = 0;
          if (mv == VT - 1) begin
            mv = 0; frames++;
          end else mv++;
        end else mh++;
      end
      e.re   = s1.act;
      e.addr = held;
      e.rgb  = s3.act ? 12'(s3.pa) : 12'd0;
      e.hs_n = !s3.hs;
      e.vs_n = !s3.vs;
      e.fs   = s3.fs;
      q.push_back(e);
      #1;
      if (n < 2) rst_i = 1'b1;
      else if (!mid && frames == 2 &&
               mh == 300 && mv == 3) begin
        rst_i = 1'b1; mid = 1;
      end else rst_i = 1'b0;
      if (mid) tail++;
      if (tail > 3000) break;
    end
    @(negedge clk);
    #1 done = 1;
    if (!per_done) begin
      n_chk++;
      $display("FAIL fs_period: no second frame_start");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    int cyc, f1, sf;
    cyc = 0; f1 = -1;
    forever begin
      @(negedge clk);
      if (done) break;
      cyc++;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL queue: empty at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("read_en", read_en_o, e.re);
        chk("read_addr", read_address_o, e.addr);
        chk("rgb", rgb_o, e.rgb);
        chk("hsync", hsync_o, e.hs_n);
        chk("vsync", vsync_o, e.vs_n);
        chk("frame_start", frame_start_o, e.fs);
      end
      if (read_en_o === 1'b1) begin
        n_chk++;
        if (read_address_o <= 17'(MAXA)) n_pass++;
        else $display("FAIL addr_range: got %0d max %0d",
                      read_address_o, MAXA);
      end
      if (frame_start_o === 1'b1) begin
        if (f1 < 0) f1 = cyc;
        else if (!per_done) begin
          chk("fs_period", cyc - f1, FRAME);
          per_done = 1;
        end
      end
      if (f1 >= 0 && !per_done) begin
        sf = cyc - f1;
        case (sf)
          2:    chk("rgb_px2_0", rgb_o, 1);
          637:  chk("l0_end_addr", read_address_o, 319);
          638:  chk("l0_end_re", read_en_o, 0);
          655:  chk("hs_pre", hsync_o, 1);
          656:  chk("hs_start", hsync_o, 0);
          700:  chk("rgb_hblank", rgb_o, 0);
          751:  chk("hs_last", hsync_o, 0);
          752:  chk("hs_end", hsync_o, 1);
          798:  chk("l1_start", read_address_o, 0);
          1439: chk("rgb_px639_1", rgb_o, 319);
          1598: chk("l2_start", read_address_o, 320);
          2405: chk("rgb_px5_3", rgb_o, 322);
          4637: chk("last_addr", read_address_o, MAXA);
          4638: chk("last_re", read_en_o, 0);
          4810: chk("rgb_vblank", rgb_o, 0);
          6399: chk("vs_pre", vsync_o, 1);
          6400: chk("vs_start", vsync_o, 0);
          7100: chk("hs_in_vblank", hsync_o, 0);
          7999: chk("vs_last", vsync_o, 0);
          8000: chk("vs_end", vsync_o, 1);
          default: ;
        endcase
      end
    end
  end

endmodule
